// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that fills instruction RAM and releases fetch
module imem_loader #(
    parameter int START_CYCLES = 2,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  byte_ready_o,
    input  logic                  reload_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [15:0]           imem_data_o,
    output logic                  start_o,
    output logic [ADDR_WIDTH-1:0] start_address_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [2:0] {
        S_ADDR_HI,
        S_ADDR_LO,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_START,
        S_DONE
    } state_t;

    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);

    state_t                state;
    state_t                nextState;
    logic                  readyReg;
    logic                  reloaded;
    logic [7:0]            hiByte;
    logic [ADDR_WIDTH-1:0] baseReg;
    logic [15:0]           countReg;
    logic [15:0]           idx;
    logic [SCW-1:0]        startCnt;
    logic                  imemWe;
    logic [ADDR_WIDTH-1:0] imemAddr;
    logic [15:0]           imemData;
    logic [ADDR_WIDTH-1:0] startAddr;
    logic                  accept;
    logic [15:0]           fieldWord;

    // readyReg is a registered state decode, so accept never loops back through byte_valid_i
    assign accept    = byte_valid_i && readyReg;
    assign fieldWord = {hiByte, byte_i};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ADDR_HI;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode: header fields, data words, start pulse, then park in done
    always_comb begin
        nextState = state;
        case (state)
            S_ADDR_HI: if (accept) nextState = S_ADDR_LO;
            S_ADDR_LO: if (accept) nextState = S_CNT_HI;
            S_CNT_HI:  if (accept) nextState = S_CNT_LO;
            S_CNT_LO: begin
                if (accept) begin
                    nextState = (fieldWord == 16'd0) ? S_START : S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) nextState = S_DATA_LO;
            S_DATA_LO: begin
                if (accept) begin
                    nextState = ((idx + 16'd1) == countReg) ? S_START : S_DATA_HI;
                end
            end
            S_START:   if (startCnt == START_LAST) nextState = S_DONE;
            S_DONE:    if (reload_i) nextState = S_ADDR_HI;
            default:   nextState = S_ADDR_HI;
        endcase
    end

    // Field capture, word write strobe and start-pulse bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readyReg  <= 1'b1;
            reloaded  <= 1'b0;
            hiByte    <= 8'd0;
            baseReg   <= '0;
            countReg  <= 16'd0;
            idx       <= 16'd0;
            startCnt  <= '0;
            imemWe    <= 1'b0;
            imemAddr  <= '0;
            imemData  <= 16'd0;
            startAddr <= '0;
        end else begin
            imemWe   <= 1'b0;
            readyReg <= (nextState != S_START) && (nextState != S_DONE);
            if (accept) begin
                case (state)
                    S_ADDR_HI, S_CNT_HI, S_DATA_HI: hiByte <= byte_i;
                    S_ADDR_LO: baseReg <= ADDR_WIDTH'(fieldWord);
                    S_CNT_LO: begin
                        countReg <= fieldWord;
                        idx      <= 16'd0;
                    end
                    S_DATA_LO: begin
                        imemWe   <= 1'b1;
                        imemAddr <= baseReg + ADDR_WIDTH'(idx);
                        imemData <= fieldWord;
                        idx      <= idx + 16'd1;
                    end
                    default: ;
                endcase
            end
            if (state == S_START) begin
                startCnt <= startCnt + 1'b1;
            end else begin
                startCnt <= '0;
            end
            if ((nextState == S_START) && (state != S_START)) begin
                startAddr <= baseReg;
            end
            if ((state == S_DONE) && reload_i) begin
                reloaded <= 1'b1;
            end
        end
    end

    // Reset forces ready low immediately; the idle header state only counts as busy after a reload
    assign byte_ready_o    = readyReg && !rst;
    assign imem_we_o       = imemWe;
    assign imem_addr_o     = imemAddr;
    assign imem_data_o     = imemData;
    assign start_o         = (state == S_START);
    assign start_address_o = startAddr;
    assign done_o          = (state == S_DONE);
    assign busy_o          = (state != S_DONE) && !((state == S_ADDR_HI) && !reloaded);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        reload_i;
    logic        imem_we_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_data_o;
    logic        start_o;
    logic [15:0] start_address_o;
    logic        busy_o;
    logic        done_o;

    int errCount;
    int checkCount;
    int cyc;

    logic [7:0]  txq[$];
    logic [15:0] wrAddr[$];
    logic [15:0] wrData[$];
    int          wrCycle[$];
    int          startCycles;
    int          firstStart;
    logic [15:0] startAddrSeen;

    imem_loader #(.START_CYCLES(2), .ADDR_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .byte_valid_i    (byte_valid_i),
        .byte_i          (byte_i),
        .byte_ready_o    (byte_ready_o),
        .reload_i        (reload_i),
        .imem_we_o       (imem_we_o),
        .imem_addr_o     (imem_addr_o),
        .imem_data_o     (imem_data_o),
        .start_o         (start_o),
        .start_address_o (start_address_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log writes and start pulses away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (imem_we_o) begin
            wrAddr.push_back(imem_addr_o);
            wrData.push_back(imem_data_o);
            wrCycle.push_back(cyc);
        end
        if (start_o) begin
            if (startCycles == 0) firstStart = cyc;
            startCycles = startCycles + 1;
            startAddrSeen = start_address_o;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        wrAddr.delete();
        wrData.delete();
        wrCycle.delete();
        startCycles = 0;
        firstStart  = -1;
        startAddrSeen = 16'h0;
    endtask

    // Offer each byte of txq until taken; gap inserts one idle (garbage) cycle after each accept
    task automatic sendBytes(input int gap);
        for (int i = 0; i < txq.size(); i++) begin
            int  tries;
            bit  took;
            tries = 0;
            took  = 1'b0;
            while (!took && tries < 20) begin
                @(negedge clk);
                byte_valid_i = 1'b1;
                byte_i       = txq[i];
                took         = byte_ready_o;
                @(posedge clk);
                tries++;
            end
            if (!took) checkVal("accept_timeout", 32'd0, 32'd1);
            if (gap != 0) begin
                @(negedge clk);
                byte_valid_i = 1'b0;
                byte_i       = 8'hA5;
                @(posedge clk);
            end
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, {31'd0, done_o}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic doReload();
        @(negedge clk);
        reload_i = 1'b1;
        @(negedge clk);
        reload_i = 1'b0;
        checkVal("reload_busy", {31'd0, busy_o}, 32'd1);
        checkVal("reload_ready", {31'd0, byte_ready_o}, 32'd1);
        checkVal("reload_not_done", {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        errCount     = 0;
        checkCount   = 0;
        cyc          = 0;
        rst          = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        reload_i     = 1'b0;
        clearLog();

        // Reset state
        repeat (3) @(negedge clk);
        checkVal("rst_ready", {31'd0, byte_ready_o}, 32'd0);
        checkVal("rst_we", {31'd0, imem_we_o}, 32'd0);
        checkVal("rst_start", {31'd0, start_o}, 32'd0);
        checkVal("rst_busy", {31'd0, busy_o}, 32'd0);
        checkVal("rst_done", {31'd0, done_o}, 32'd0);
        checkVal("rst_addr", {16'd0, imem_addr_o}, 32'd0);
        rst = 1'b0;
        #1;
        checkVal("post_rst_ready", {31'd0, byte_ready_o}, 32'd1);
        checkVal("post_rst_busy", {31'd0, busy_o}, 32'd0);

        // Scenario 1: two words, continuous bytes
        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        sendBytes(0);
        waitDone("s1_done");
        checkVal("s1_nwr", wrAddr.size(), 32'd2);
        if (wrAddr.size() == 2) begin
            checkVal("s1_a0", {16'd0, wrAddr[0]}, 32'h0010);
            checkVal("s1_d0", {16'd0, wrData[0]}, 32'h1234);
            checkVal("s1_a1", {16'd0, wrAddr[1]}, 32'h0011);
            checkVal("s1_d1", {16'd0, wrData[1]}, 32'hABCD);
            checkVal("s1_spacing", wrCycle[1] - wrCycle[0], 32'd2);
            checkVal("s1_start_with_last_write", firstStart, wrCycle[1]);
        end
        checkVal("s1_start_len", startCycles, 32'd2);
        checkVal("s1_start_addr", {16'd0, startAddrSeen}, 32'h0010);
        checkVal("s1_hold_addr", {16'd0, start_address_o}, 32'h0010);
        checkVal("s1_addr_hold", {16'd0, imem_addr_o}, 32'h0011);
        checkVal("s1_data_hold", {16'd0, imem_data_o}, 32'hABCD);
        checkVal("s1_busy_done", {31'd0, busy_o}, 32'd0);
        checkVal("s1_ready_done", {31'd0, byte_ready_o}, 32'd0);

        // Scenario 2: zero-length payload
        doReload();
        clearLog();
        txq = '{8'h40, 8'h00, 8'h00, 8'h00};
        sendBytes(0);
        waitDone("s2_done");
        checkVal("s2_nwr", wrAddr.size(), 32'd0);
        checkVal("s2_start_len", startCycles, 32'd2);
        checkVal("s2_start_addr", {16'd0, startAddrSeen}, 32'h4000);

        // Scenario 3: address wrap
        doReload();
        clearLog();
        txq = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};
        sendBytes(0);
        waitDone("s3_done");
        checkVal("s3_nwr", wrAddr.size(), 32'd2);
        if (wrAddr.size() == 2) begin
            checkVal("s3_a0", {16'd0, wrAddr[0]}, 32'hFFFF);
            checkVal("s3_d0", {16'd0, wrData[0]}, 32'h0001);
            checkVal("s3_a1", {16'd0, wrAddr[1]}, 32'h0000);
            checkVal("s3_d1", {16'd0, wrData[1]}, 32'h0002);
        end
        checkVal("s3_start_addr", {16'd0, startAddrSeen}, 32'hFFFF);

        // Scenario 4: valid toggling every cycle
        doReload();
        clearLog();
        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        sendBytes(1);
        waitDone("s4_done");
        checkVal("s4_nwr", wrAddr.size(), 32'd2);
        if (wrAddr.size() == 2) begin
            checkVal("s4_a0", {16'd0, wrAddr[0]}, 32'h0010);
            checkVal("s4_d0", {16'd0, wrData[0]}, 32'h1234);
            checkVal("s4_a1", {16'd0, wrAddr[1]}, 32'h0011);
            checkVal("s4_d1", {16'd0, wrData[1]}, 32'hABCD);
        end
        checkVal("s4_start_len", startCycles, 32'd2);
        checkVal("s4_start_addr", {16'd0, startAddrSeen}, 32'h0010);

        // Scenario 5: reset in the middle of a word
        doReload();
        clearLog();
        txq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
        sendBytes(0);
        rst = 1'b1;
        #1;
        checkVal("s5_rst_ready", {31'd0, byte_ready_o}, 32'd0);
        checkVal("s5_rst_busy", {31'd0, busy_o}, 32'd0);
        checkVal("s5_rst_done", {31'd0, done_o}, 32'd0);
        checkVal("s5_rst_start", {31'd0, start_o}, 32'd0);
        checkVal("s5_rst_saddr", {16'd0, start_address_o}, 32'd0);
        checkVal("s5_rst_data", {16'd0, imem_data_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("s5_no_write", wrAddr.size(), 32'd0);
        checkVal("s5_idle_busy", {31'd0, busy_o}, 32'd0);
        txq = '{8'h00, 8'h20, 8'h00, 8'h01, 8'h55, 8'h66};
        sendBytes(0);
        waitDone("s5_done");
        checkVal("s5_nwr", wrAddr.size(), 32'd1);
        if (wrAddr.size() == 1) begin
            checkVal("s5_a0", {16'd0, wrAddr[0]}, 32'h0020);
            checkVal("s5_d0", {16'd0, wrData[0]}, 32'h5566);
        end
        checkVal("s5_start_addr", {16'd0, startAddrSeen}, 32'h0020);

        // Scenario 6: bytes offered in done are not taken, then reload
        clearLog();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            byte_valid_i = 1'b1;
            byte_i       = 8'h99;
            #1;
            checkVal("s6_ready_low", {31'd0, byte_ready_o}, 32'd0);
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        checkVal("s6_still_done", {31'd0, done_o}, 32'd1);
        checkVal("s6_no_write", wrAddr.size(), 32'd0);
        doReload();
        txq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h77, 8'h88};
        sendBytes(0);
        waitDone("s6_done");
        checkVal("s6_nwr", wrAddr.size(), 32'd1);
        if (wrAddr.size() == 1) begin
            checkVal("s6_a0", {16'd0, wrAddr[0]}, 32'h0000);
            checkVal("s6_d0", {16'd0, wrData[0]}, 32'h7788);
        end
        checkVal("s6_start_len", startCycles, 32'd2);
        checkVal("s6_start_addr", {16'd0, start_address_o}, 32'h0000);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
